dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-memory bridge sitting directly downstream of the core's data port. Converts the core's single-cycle load/store request into a two-phase request/response bus transaction with variable latency. Stalls the core while the access is outstanding. Handles byte/half/word lane steering, load sign-extension, misalignment and bus timeout.

## Interface
- TIMEOUT, 255: maximum cycles spent in REQ or RESP before the access is aborted with an error (1..65535).
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- core_valid  in  1  core presents a memory access; held stable until core_done.
- core_addr  in  32  byte address.
- core_we  in  1  1 = store, 0 = load.
- core_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- core_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- core_wdata  in  32  store data, right-justified.
- core_rdata  out  32  extended load data; valid only while core_done = 1.
- core_done  out  1  one-cycle completion pulse.
- core_err  out  1  qualifies core_done: access was misaligned or timed out.
- core_stall  out  1  core_valid & ~core_done (combinational).
- bus_req  out  1  request valid.
- bus_addr  out  32  word-aligned address ({core_addr[31:2], 2'b00}).
- bus_we  out  1  write request.
- bus_strb  out  4  byte-lane enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ready  in  1  bus accepts request this cycle.
- bus_rvalid  in  1  response (read data or write ack).
- bus_rdata  in  32  read data.

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE: if core_valid: misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE with err flag set, no bus activity; else capture addr/we/size/unsigned/wdata into request regs -> REQ.
- REQ: bus_req = 1, outputs from captured regs. bus_ready=1 -> RESP.
- RESP: bus_req = 0. bus_rvalid=1 -> capture bus_rdata -> DONE.
- Timeout: counter cleared on IDLE->REQ and REQ->RESP, increments each cycle in REQ/RESP; reaching TIMEOUT -> DONE with err set, bus_req dropped.
- DONE: core_done = 1 for exactly one cycle, then IDLE unconditionally.
- Strobes: byte 4'b0001 << addr[1:0]; half 4'b0011 << addr[1:0]; word 4'b1111.
- bus_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extract: byte = rdata lane addr[1:0]; half = lane pair addr[1]; extended to 32 per core_unsigned. Stores and error completions drive core_rdata = 0.
- bus_rvalid outside RESP is ignored (covers late response after timeout).

## Timing
- Reset: state IDLE, bus_req/bus_we 0, bus_strb 0, bus_addr/bus_wdata 0, core_done/core_err 0, core_rdata 0, timeout counter 0. Reset mid-access drops bus_req immediately and aborts without core_done.
- bus_req asserts the cycle after core_valid is seen in IDLE; registered, no combinational path from core inputs to bus outputs.
- Zero-wait bus (ready and rvalid each one cycle after the prior handshake): core_valid at cycle 0 -> bus_req cycle 1 -> rvalid cycle 2 -> core_done cycle 3. Minimum latency 3 cycles.
- Misaligned: core_done+core_err at cycle 1.
- bus_ready and bus_rvalid in the same cycle while in REQ: only ready is honoured; the response must come later.
- Back-to-back: new core_valid is sampled in IDLE the cycle after DONE.

## Structure
- Shared package pipes: typedef mem_size_t (enum BYTE/HALF/WORD), typedef dmem_req_t struct (addr, we, size, unsign, wdata), state enum dmem_state_t.
- Types u32/word_t/u4 from common.
- One natural sub-module: dmem_lane, combinational strobe/wdata replication and load extract/extend.

## Test plan
- Aligned word load, zero-wait bus, rdata 0xDEADBEEF -> core_done at cycle 3, core_rdata 0xDEADBEEF, err 0.
- Signed byte load addr 0x103, rdata 0x80112233 -> bus_addr 0x100, strb 0000 on read, core_rdata 0xFFFFFF80; unsigned -> 0x00000080.
- Half store addr 0x202, wdata 0x0000ABCD -> bus_strb 1100, bus_wdata 0xABCDABCD, bus_we 1.
- Word load addr 0x105 -> no bus_req, core_done+core_err at cycle 1.
- TIMEOUT=4, bus never asserts rvalid -> err completion; late rvalid afterwards ignored, next access completes normally.
- reset low during RESP -> bus_req/core_done 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// ----------------------------------------------------------------------------
// dmem_bridge_pkg
// Shared types for the data-memory bridge: basic word/strobe types, the
// access-size and state enums, the captured request record, and two small
// helpers that decode the raw core size field and detect misalignment.
// No ports (package).
// ----------------------------------------------------------------------------
package dmem_bridge_pkg;

    typedef logic [31:0] u32;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  u4;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } dmem_state_t;

    typedef struct packed {
        u32        addr;
        logic      we;
        mem_size_t size;
        logic      unsign;
        word_t     wdata;
    } dmem_req_t;

    // Width of the timeout counter; large enough for any legal TIMEOUT.
    localparam int unsigned CNT_W = 16;

    // The core encodes size 3 as well; it behaves exactly like a word access.
    function automatic mem_size_t decode_size(input logic [1:0] raw);
        mem_size_t sz;
        case (raw)
            2'd0:    sz = BYTE;
            2'd1:    sz = HALF;
            default: sz = WORD;
        endcase
        return sz;
    endfunction

    // Bytes never straddle lanes, so only half and word accesses can be misaligned.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
        logic mis;
        case (size)
            HALF:    mis = offset[0];
            WORD:    mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// ----------------------------------------------------------------------------
// dmem_lane
// Purely combinational lane steering for the bridge.
//   req_i   : captured request (address offset, size, signedness, store data)
//   rdata_i : raw 32-bit read data from the bus
//   strb_o  : byte-lane enables for the addressed bytes
//   wdata_o : store data replicated across every lane of its size
//   load_o  : addressed byte/half extracted and zero/sign-extended to 32 bits
// ----------------------------------------------------------------------------
module dmem_lane
    import dmem_bridge_pkg::*;
(
    input  dmem_req_t req_i,
    input  word_t     rdata_i,
    output u4         strb_o,
    output word_t     wdata_o,
    output word_t     load_o
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Strobes shift with the byte offset; store data is replicated so the
    // addressed lane holds it whichever offset is used.
    always_comb begin
        strb_o  = 4'b1111;
        wdata_o = req_i.wdata;
        case (req_i.size)
            BYTE: begin
                strb_o  = 4'b0001 << req_i.addr[1:0];
                wdata_o = {4{req_i.wdata[7:0]}};
            end
            HALF: begin
                strb_o  = 4'b0011 << req_i.addr[1:0];
                wdata_o = {2{req_i.wdata[15:0]}};
            end
            default: begin
            end
        endcase
    end

    // Pick the addressed byte and half out of the returned word.
    always_comb begin
        case (req_i.addr[1:0])
            2'd0:    byteLane = rdata_i[7:0];
            2'd1:    byteLane = rdata_i[15:8];
            2'd2:    byteLane = rdata_i[23:16];
            default: byteLane = rdata_i[31:24];
        endcase
        halfLane = req_i.addr[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Right-justify and extend according to size and signedness.
    always_comb begin
        case (req_i.size)
            BYTE:    load_o = req_i.unsign ? {24'd0, byteLane} : {{24{byteLane[7]}}, byteLane};
            HALF:    load_o = req_i.unsign ? {16'd0, halfLane} : {{16{halfLane[15]}}, halfLane};
            default: load_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// ----------------------------------------------------------------------------
// dmem_bridge
// Turns a single-cycle core load/store into a request/response bus
// transaction, stalling the core until it completes.
//   clk, reset (async, active-low)
//   core_valid/addr/we/size/unsigned/wdata : access from the core
//   core_rdata/done/err/stall              : completion back to the core
//   bus_req/addr/we/strb/wdata             : registered bus request
//   bus_ready, bus_rvalid, bus_rdata       : bus handshake and response
// TIMEOUT bounds the cycles spent in REQ or in RESP before erroring out.
// ----------------------------------------------------------------------------
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_valid,
    input  logic [31:0] core_addr,
    input  logic        core_we,
    input  logic [1:0]  core_size,
    input  logic        core_unsigned,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_done,
    output logic        core_err,
    output logic        core_stall,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_strb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W:0] TIMEOUT_LIMIT = (CNT_W+1)'(TIMEOUT);

    dmem_state_t      state_q, state_d;
    dmem_req_t        req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    word_t            rdata_q, rdata_d;
    logic             err_q, err_d;

    u4                laneStrb;
    word_t            laneWdata;
    word_t            laneLoad;
    logic [CNT_W:0]   cntInc;
    logic             timedOut;
    mem_size_t        coreSize;

    dmem_lane u_lane (
        .req_i   (req_q),
        .rdata_i (bus_rdata),
        .strb_o  (laneStrb),
        .wdata_o (laneWdata),
        .load_o  (laneLoad)
    );

    assign coreSize = decode_size(core_size);
    assign cntInc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign timedOut = (cntInc >= TIMEOUT_LIMIT);

    // State register; reset abandons any access in flight without a completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured request, timeout counter and completion data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. A handshake always wins over a timeout landing in the
    // same cycle, and an rvalid seen while still in REQ is deliberately ignored.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (core_valid) begin
                    rdata_d = '0;
                    if (is_misaligned(coreSize, core_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        req_d.addr   = core_addr;
                        req_d.we     = core_we;
                        req_d.size   = coreSize;
                        req_d.unsign = core_unsigned;
                        req_d.wdata  = core_wdata;
                        err_d        = 1'b0;
                        state_d      = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_ready) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (timedOut) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cntInc[CNT_W-1:0];
                end
            end
            RESP: begin
                if (bus_rvalid) begin
                    rdata_d = req_q.we ? '0 : laneLoad;
                    state_d = DONE;
                end else if (timedOut) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cntInc[CNT_W-1:0];
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come only from registers, so nothing on the core side can
    // reach the bus combinationally. Strobes and write enable are quiet
    // outside a store request.
    always_comb begin
        bus_req    = (state_q == REQ);
        bus_addr   = {req_q.addr[31:2], 2'b00};
        bus_we     = (state_q == REQ) && req_q.we;
        bus_strb   = ((state_q == REQ) && req_q.we) ? laneStrb : 4'b0000;
        bus_wdata  = laneWdata;
        core_done  = (state_q == DONE);
        core_err   = (state_q == DONE) && err_q;
        core_rdata = (state_q == DONE) ? rdata_q : '0;
        core_stall = core_valid && (state_q != DONE);
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// ----------------------------------------------------------------------------
// tb_dmem_bridge
// Self-checking bench for dmem_bridge: a table of directed accesses, a set of
// randomized accesses scored against a transaction-level model, and
// hand-written sequences for late responses and reset in mid-access.
// ----------------------------------------------------------------------------
module tb_dmem_bridge;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_valid;
    logic [31:0] core_addr;
    logic        core_we;
    logic [1:0]  core_size;
    logic        core_unsigned;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_done;
    logic        core_err;
    logic        core_stall;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_strb;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdly;
        int          vdly;
        bit          dup;
    } acc_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          reqCycles;
        logic [31:0] baddr;
        logic [3:0]  strb;
        logic [31:0] bwdata;
    } exp_t;

    typedef struct {
        acc_t a;
        exp_t e;
    } vec_t;

    vec_t vecs[14];

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .core_valid    (core_valid),
        .core_addr     (core_addr),
        .core_we       (core_we),
        .core_size     (core_size),
        .core_unsigned (core_unsigned),
        .core_wdata    (core_wdata),
        .core_rdata    (core_rdata),
        .core_done     (core_done),
        .core_err      (core_err),
        .core_stall    (core_stall),
        .bus_req       (bus_req),
        .bus_addr      (bus_addr),
        .bus_we        (bus_we),
        .bus_strb      (bus_strb),
        .bus_wdata     (bus_wdata),
        .bus_ready     (bus_ready),
        .bus_rvalid    (bus_rvalid),
        .bus_rdata     (bus_rdata)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Advance to the sampling/driving point of the next cycle.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Reference model: what one access should look like at transaction level.
    function automatic exp_t model(input acc_t a);
        exp_t        e;
        int          nb;
        int          off;
        logic [31:0] mask;
        logic [31:0] val;
        nb  = (a.size == 2'd0) ? 1 : (a.size == 2'd1) ? 2 : 4;
        off = int'(a.addr % 4);
        e.baddr  = a.addr - 32'(off);
        e.strb   = 4'b0000;
        e.bwdata = '0;
        e.rdata  = '0;
        for (int i = 0; i < 4; i++) begin
            if (a.we && i >= off && i < off + nb) e.strb[i] = 1'b1;
            e.bwdata[8*i +: 8] = a.wdata[8*(i % nb) +: 8];
        end
        if (off % nb != 0) begin
            e.err = 1'b1; e.lat = 1; e.reqCycles = 0;
            return e;
        end
        if (a.rdly >= TMO) begin
            e.err = 1'b1; e.lat = 1 + TMO; e.reqCycles = TMO;
        end else if (a.vdly >= TMO) begin
            e.err = 1'b1; e.lat = 2 + a.rdly + TMO; e.reqCycles = a.rdly + 1;
        end else begin
            e.err = 1'b0; e.lat = a.rdly + a.vdly + 3; e.reqCycles = a.rdly + 1;
        end
        if (!e.err && !a.we) begin
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
            val  = (a.rdata >> (8 * off)) & mask;
            if (!a.uns && nb < 4 && val[8*nb-1]) val = val | ~mask;
            e.rdata = val;
        end
        return e;
    endfunction

    // Drives one access from the core side and plays the bus slave with the
    // requested ready/rvalid delays; checks bus request fields and completion.
    // Entered and left at the drive point of a cycle.
    task automatic applyStimulus(input acc_t a, input exp_t e, input string tag);
        int reqCount  = 0;
        int respCount = 0;
        bit respPhase = 0;
        bit seen      = 0;
        int cyc;
        core_valid    = 1'b1;
        core_addr     = a.addr;
        core_we       = a.we;
        core_size     = a.size;
        core_unsigned = a.uns;
        core_wdata    = a.wdata;
        #1;
        checkOutput({tag, ".stall"}, 32'(core_stall), 32'd1);
        for (cyc = 0; cyc < 40; cyc++) begin
            if (core_done) begin
                seen = 1;
                break;
            end
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
            if (respPhase) begin
                if (respCount == a.vdly) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = a.rdata;
                end
                respCount++;
            end
            if (bus_req) begin
                if (reqCount == 0) begin
                    checkOutput({tag, ".bus_addr"}, bus_addr, e.baddr);
                    checkOutput({tag, ".bus_we"}, 32'(bus_we), 32'(a.we));
                    checkOutput({tag, ".bus_strb"}, 32'(bus_strb), 32'(e.strb));
                    checkOutput({tag, ".bus_wdata"}, bus_wdata, e.bwdata);
                end
                if (reqCount == a.rdly) begin
                    bus_ready = 1'b1;
                    respPhase = 1;
                    if (a.dup) begin
                        bus_rvalid = 1'b1;
                        bus_rdata  = ~a.rdata;
                    end
                end
                reqCount++;
            end
            step();
        end
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.done: no core_done within 40 cycles, expected at cycle %0d", tag, e.lat);
        end else begin
            checkOutput({tag, ".latency"}, 32'(cyc), 32'(e.lat));
            checkOutput({tag, ".err"}, 32'(core_err), 32'(e.err));
            checkOutput({tag, ".rdata"}, core_rdata, e.rdata);
            checkOutput({tag, ".req_cycles"}, 32'(reqCount), 32'(e.reqCycles));
            checkOutput({tag, ".stall_at_done"}, 32'(core_stall), 32'd0);
        end
        step();
        core_valid = 1'b0;
    endtask

    initial begin
        acc_t a;
        exp_t e;

        // Directed table: {addr, we, size, uns, wdata, rdata, rdly, vdly, dup},
        //                 {rdata, err, latency, req cycles, bus_addr, strb, bus_wdata}
        vecs[0]  = '{'{32'h1000, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0},
                     '{32'hDEADBEEF, 1'b0, 3, 1, 32'h1000, 4'b0000, 32'h0}};
        vecs[1]  = '{'{32'h0103, 1'b0, 2'd0, 1'b0, 32'h0, 32'h80112233, 0, 0, 1'b0},
                     '{32'hFFFFFF80, 1'b0, 3, 1, 32'h0100, 4'b0000, 32'h0}};
        vecs[2]  = '{'{32'h0103, 1'b0, 2'd0, 1'b1, 32'h0, 32'h80112233, 0, 0, 1'b0},
                     '{32'h00000080, 1'b0, 3, 1, 32'h0100, 4'b0000, 32'h0}};
        vecs[3]  = '{'{32'h0202, 1'b1, 2'd1, 1'b0, 32'h0000ABCD, 32'h55555555, 0, 0, 1'b0},
                     '{32'h0, 1'b0, 3, 1, 32'h0200, 4'b1100, 32'hABCDABCD}};
        vecs[4]  = '{'{32'h0105, 1'b0, 2'd2, 1'b0, 32'h0, 32'h12345678, 0, 0, 1'b0},
                     '{32'h0, 1'b1, 1, 0, 32'h0104, 4'b0000, 32'h0}};
        vecs[5]  = '{'{32'h0301, 1'b0, 2'd1, 1'b0, 32'h0, 32'h12345678, 0, 0, 1'b0},
                     '{32'h0, 1'b1, 1, 0, 32'h0300, 4'b0000, 32'h0}};
        vecs[6]  = '{'{32'h0302, 1'b0, 2'd1, 1'b0, 32'h0, 32'h80011234, 2, 1, 1'b0},
                     '{32'hFFFF8001, 1'b0, 6, 3, 32'h0300, 4'b0000, 32'h0}};
        vecs[7]  = '{'{32'h0401, 1'b1, 2'd0, 1'b0, 32'h123456A5, 32'h0, 0, 2, 1'b0},
                     '{32'h0, 1'b0, 5, 1, 32'h0400, 4'b0010, 32'hA5A5A5A5}};
        vecs[8]  = '{'{32'h0500, 1'b0, 2'd3, 1'b0, 32'hCAFEF00D, 32'h11223344, 1, 0, 1'b0},
                     '{32'h11223344, 1'b0, 4, 2, 32'h0500, 4'b0000, 32'hCAFEF00D}};
        vecs[9]  = '{'{32'h0600, 1'b0, 2'd2, 1'b0, 32'h0, 32'h00000001, 4, 0, 1'b0},
                     '{32'h0, 1'b1, 5, 4, 32'h0600, 4'b0000, 32'h0}};
        vecs[10] = '{'{32'h0700, 1'b1, 2'd2, 1'b0, 32'h87654321, 32'h0, 0, 4, 1'b0},
                     '{32'h0, 1'b1, 6, 1, 32'h0700, 4'b1111, 32'h87654321}};
        vecs[11] = '{'{32'h0800, 1'b0, 2'd2, 1'b1, 32'h0, 32'h0BADF00D, 1, 2, 1'b1},
                     '{32'h0BADF00D, 1'b0, 6, 2, 32'h0800, 4'b0000, 32'h0}};
        vecs[12] = '{'{32'h0102, 1'b0, 2'd0, 1'b1, 32'h0, 32'h80112233, 0, 0, 1'b0},
                     '{32'h00000011, 1'b0, 3, 1, 32'h0100, 4'b0000, 32'h0}};
        vecs[13] = '{'{32'h0106, 1'b0, 2'd1, 1'b1, 32'h0, 32'h80112233, 0, 0, 1'b0},
                     '{32'h00008011, 1'b0, 3, 1, 32'h0104, 4'b0000, 32'h0}};

        reset         = 1'b0;
        core_valid    = 1'b0;
        core_addr     = '0;
        core_we       = 1'b0;
        core_size     = 2'd0;
        core_unsigned = 1'b0;
        core_wdata    = '0;
        bus_ready     = 1'b0;
        bus_rvalid    = 1'b0;
        bus_rdata     = '0;

        // Reset values.
        @(negedge clk);
        #1;
        checkOutput("reset.bus_req", 32'(bus_req), 32'd0);
        checkOutput("reset.bus_we", 32'(bus_we), 32'd0);
        checkOutput("reset.bus_strb", 32'(bus_strb), 32'd0);
        checkOutput("reset.bus_addr", bus_addr, 32'd0);
        checkOutput("reset.bus_wdata", bus_wdata, 32'd0);
        checkOutput("reset.core_done", 32'(core_done), 32'd0);
        checkOutput("reset.core_err", 32'(core_err), 32'd0);
        checkOutput("reset.core_rdata", core_rdata, 32'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].a, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Late response after an rvalid timeout must be ignored.
        a = '{32'h0A00, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 5, 1'b0};
        applyStimulus(a, model(a), "late.timeout");
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("late.ignored_done%0d", i), 32'(core_done), 32'd0);
            checkOutput($sformatf("late.ignored_req%0d", i), 32'(bus_req), 32'd0);
        end
        bus_rvalid = 1'b0;
        a = '{32'h0A04, 1'b0, 2'd2, 1'b0, 32'h0, 32'h600DF00D, 0, 0, 1'b0};
        applyStimulus(a, model(a), "late.next");

        // Reset in REQ (phase 1) and in RESP (phase 2).
        for (int phase = 1; phase <= 2; phase++) begin
            core_valid = 1'b1;
            core_addr  = 32'h0900;
            core_we    = 1'b0;
            core_size  = 2'd2;
            step();
            checkOutput($sformatf("rst%0d.req_before", phase), 32'(bus_req), 32'd1);
            if (phase == 2) begin
                bus_ready = 1'b1;
                step();
                bus_ready = 1'b0;
            end
            reset      = 1'b0;
            core_valid = 1'b0;
            #1;
            checkOutput($sformatf("rst%0d.bus_req", phase), 32'(bus_req), 32'd0);
            checkOutput($sformatf("rst%0d.core_done", phase), 32'(core_done), 32'd0);
            step();
            step();
            reset = 1'b1;
            step();
            checkOutput($sformatf("rst%0d.idle_req", phase), 32'(bus_req), 32'd0);
            checkOutput($sformatf("rst%0d.idle_done", phase), 32'(core_done), 32'd0);
            a = '{32'h0904, 1'b0, 2'd1, 1'b0, 32'h0, 32'h0000C001, 0, 0, 1'b0};
            applyStimulus(a, model(a), $sformatf("rst%0d.next", phase));
        end

        // Randomized accesses against the model.
        for (int i = 0; i < 60; i++) begin
            a.addr  = $urandom;
            a.we    = 1'($urandom_range(0, 1));
            a.size  = 2'($urandom_range(0, 3));
            a.uns   = 1'($urandom_range(0, 1));
            a.wdata = $urandom;
            a.rdata = $urandom;
            a.rdly  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 2));
            a.vdly  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 2));
            a.dup   = ($urandom_range(0, 3) == 0);
            e = model(a);
            applyStimulus(a, e, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
